// File: rtl/dma_read_stream.sv
// AXI4 read master: on an INIT edge, issues C_NUM_BURSTS incrementing bursts from the base
// address and forwards each returned beat onto an AXI4-Stream master with zero latency.
module dma_read_stream #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_NUM_BURSTS       = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          INIT_AXI_TXN,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic [1:0]                    dbg_state
);

  // Valid/ready: a transfer happens on every rising edge where valid && ready are both high;
  // a source that raises valid keeps it and its payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BIDX_W = (C_NUM_BURSTS > 1) ? $clog2(C_NUM_BURSTS) : 1;
  localparam logic [7:0]        LAST_BEAT  = 8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [BIDX_W-1:0] LAST_BURST = BIDX_W'(C_NUM_BURSTS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * 4);

  state_t                        state;
  state_t                        state_nxt;
  logic                          init_q;
  logic [7:0]                    beat_cnt;
  logic [BIDX_W-1:0]             burst_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr;
  logic                          error_q;

  logic start;
  logic can_start;
  logic in_data;
  logic beat;
  logic end_of_burst;
  logic last_burst;
  logic bad_beat;

  assign start        = INIT_AXI_TXN & ~init_q;
  assign can_start    = (state == IDLE) || (state == DONE);
  assign in_data      = (state == DATA);
  assign beat         = in_data & M_AXI_RVALID & M_AXIS_TREADY;
  assign end_of_burst = (beat_cnt == LAST_BEAT);
  assign last_burst   = (burst_idx == LAST_BURST);
  // A missing RLAST still ends the burst on the beat count; only the flag records it.
  assign bad_beat     = M_AXI_RRESP[1] | (M_AXI_RLAST != end_of_burst);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ADDR;
      ADDR:       if (M_AXI_ARREADY) state_nxt = DATA;
      DATA:       if (beat && end_of_burst) state_nxt = last_burst ? DONE : ADDR;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q    <= 1'b0;
      beat_cnt  <= '0;
      burst_idx <= '0;
      araddr    <= '0;
      error_q   <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (can_start && start) begin
        burst_idx <= '0;
        beat_cnt  <= '0;
        araddr    <= C_M_TARGET_SLAVE_BASE_ADDR;
        error_q   <= 1'b0;
      end else if ((state == ADDR) && M_AXI_ARREADY) begin
        beat_cnt <= '0;
      end else if (beat) begin
        if (bad_beat) error_q <= 1'b1;
        if (end_of_burst) begin
          beat_cnt <= '0;
          if (!last_burst) begin
            burst_idx <= burst_idx + 1'b1;
            araddr    <= araddr + BURST_BYTES;
          end
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign M_AXI_ARADDR  = araddr;
  assign M_AXI_ARLEN   = LAST_BEAT;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = (state == ADDR);
  assign M_AXI_RREADY  = in_data & M_AXIS_TREADY;
  assign M_AXIS_TVALID = in_data & M_AXI_RVALID;
  assign M_AXIS_TDATA  = in_data ? M_AXI_RDATA : '0;
  assign M_AXIS_TLAST  = in_data & end_of_burst & last_burst;
  assign TXN_DONE      = (state == DONE);
  assign ERROR         = error_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dma_read_stream.sv
// Bench for dma_read_stream: AXI read slave model returning data = address, with optional
// response/RLAST faults and random stalls, checked against an address-arithmetic reference.
module tb_dma_read_stream;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int LEN = 16;
  localparam int NB  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic        txn_done;
  logic        error;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b1;
  logic [1:0]  dbg_state;

  dma_read_stream dut (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init), .TXN_DONE(txn_done), .ERROR(error),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready), .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];
  logic [31:0] exp_ar_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- slave model configuration ----------------
  int rresp_burst = -1, rresp_beat = -1;
  int early_burst = -1, early_beat = -1;
  int miss_burst  = -1;
  bit stall_mode  = 1'b0;

  bit          ar_hs_s = 1'b0;
  bit          r_hs_s = 1'b0;
  logic [31:0] ar_addr_s = '0;
  bit          burst_active = 1'b0;
  int          beat_idx = 0;
  int          cur_burst = 0;
  logic [31:0] cur_addr = '0;
  int          cyc = 0;

  // Monitor: handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    ar_hs_s = 1'b0;
    r_hs_s  = 1'b0;
    if (rst_n) begin
      if (arvalid && arready) begin
        ar_hs_s   = 1'b1;
        ar_addr_s = araddr;
        if (exp_ar_q.size() == 0) check("ar_extra", 1, 0);
        else check("araddr", araddr, exp_ar_q.pop_front());
        check("arlen", arlen, LEN - 1);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
      end
      if (rvalid) begin
        check("rready_tracks", rready, tready);
        check("tvalid", tvalid, 1);
        check("tdata_pass", tdata, rdata);
        check("arvalid_in_data", arvalid, 0);
        if (rready) begin
          r_hs_s = 1'b1;
          if (exp_q.size() == 0) check("beat_extra", 1, 0);
          else check("stream_beat", {tlast, tdata}, exp_q.pop_front());
        end
      end else begin
        check("tvalid_idle", tvalid, 0);
      end
    end
  end

  // Slave driver: updates its outputs just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      arready = 1'b0;
      rvalid = 1'b0;
      rlast = 1'b0;
      rresp = 2'b00;
      rdata = '0;
      burst_active = 1'b0;
      beat_idx = 0;
    end else begin
      if (ar_hs_s) begin
        burst_active = 1'b1;
        beat_idx = 0;
        cur_addr = ar_addr_s;
        cur_burst = int'((ar_addr_s - BASE) / (LEN * 4));
      end
      if (r_hs_s) begin
        beat_idx++;
        if (beat_idx == LEN) burst_active = 1'b0;
      end
      arready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!(rvalid && !r_hs_s))
        rvalid = burst_active && (!stall_mode || ($urandom_range(0, 2) != 0));
      rdata = cur_addr + 32'(beat_idx * 4);
      rlast = (beat_idx == LEN - 1);
      if (cur_burst == early_burst && beat_idx == early_beat) rlast = 1'b1;
      if (cur_burst == miss_burst && beat_idx == LEN - 1) rlast = 1'b0;
      rresp = (cur_burst == rresp_burst && beat_idx == rresp_beat) ? 2'b10 : 2'b00;
    end
    tready = stall_mode ? (cyc % 3 == 0) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic load_expect();
    for (int b = 0; b < NB; b++) exp_ar_q.push_back(32'(BASE + 32'(b * LEN * 4)));
    for (int i = 0; i < NB * LEN; i++)
      exp_q.push_back({(i == NB * LEN - 1), 32'(BASE + 32'(i * 4))});
  endtask

  task automatic pulse_init();
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!txn_done && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_done"}, txn_done, 1);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_ars_left"}, exp_ar_q.size(), 0);
  endtask

  task automatic wait_burst(input int b, input int bt, input string tag);
    int n = 0;
    while (!(burst_active && cur_burst == b && beat_idx >= bt) && n < 3000) begin
      @(negedge clk); n++;
    end
    check({tag, "_reach"}, (n < 3000), 1);
  endtask

  task automatic clear_faults();
    rresp_burst = -1; rresp_beat = -1;
    early_burst = -1; early_beat = -1;
    miss_burst = -1;
  endtask

  task automatic run_clean(input string tag);
    load_expect();
    pulse_init();
    check({tag, "_done_cleared"}, txn_done, 0);
    check({tag, "_err_cleared"}, error, 0);
    wait_done(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_done", txn_done, 0);
    check("rst_error", error, 0);
    check("rst_state", dbg_state, 0);
    check("rst_tvalid", tvalid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean run, full throughput
    run_clean("t1");
    check("t1_error", error, 0);

    // 2: random RVALID stalls, TREADY high one cycle in three
    stall_mode = 1'b1;
    run_clean("t2");
    check("t2_error", error, 0);
    stall_mode = 1'b0;

    // 3: SLVERR on beat 5 of burst 2
    rresp_burst = 2; rresp_beat = 5;
    load_expect();
    pulse_init();
    wait_burst(2, 0, "t3");
    check("t3_err_before", error, 0);
    wait_done("t3");
    check("t3_error", error, 1);
    repeat (5) @(negedge clk);
    check("t3_error_sticky", error, 1);
    check("t3_done_held", txn_done, 1);
    clear_faults();
    run_clean("t3b");
    check("t3b_error", error, 0);

    // 4a: early RLAST on beat 10 of burst 0
    early_burst = 0; early_beat = 9;
    load_expect();
    pulse_init();
    wait_done("t4a");
    check("t4a_error", error, 1);
    clear_faults();

    // 4b: RLAST withheld on the 16th beat of burst 0
    miss_burst = 0;
    load_expect();
    pulse_init();
    check("t4b_err_cleared", error, 0);
    wait_done("t4b");
    check("t4b_error", error, 1);
    clear_faults();

    // 5: INIT during burst 1 is ignored, then a rerun from the base
    load_expect();
    pulse_init();
    wait_burst(1, 3, "t5");
    pulse_init();
    check("t5_busy_done", txn_done, 0);
    wait_done("t5");
    repeat (10) @(negedge clk);
    check("t5_no_extra_ar", exp_ar_q.size(), 0);
    run_clean("t5b");
    check("t5b_error", error, 0);

    // 6: reset mid-burst 2 after an earlier error, then a clean run
    rresp_burst = 0; rresp_beat = 3;
    load_expect();
    pulse_init();
    wait_burst(2, 5, "t6");
    check("t6_err_pre", error, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_arvalid", arvalid, 0);
    check("t6_araddr", araddr, 0);
    check("t6_rready", rready, 0);
    check("t6_tvalid", tvalid, 0);
    check("t6_tdata", tdata, 0);
    check("t6_tlast", tlast, 0);
    check("t6_done", txn_done, 0);
    check("t6_error", error, 0);
    check("t6_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_ar_q.delete();
    clear_faults();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle", dbg_state, 0);
    run_clean("t6b");
    check("t6b_error", error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_read_stream.md
Name: dma_read_stream

Overview:
AXI4 full read master, the read-side counterpart of the DMA write master. On an INIT pulse it issues a fixed sequence of incrementing read bursts from a base address. Returned beats are forwarded onto an AXI4-Stream master port for downstream event/readout logic. It reports completion and protocol errors through the same TXN_DONE/ERROR handshake the DMA write master uses, so both blocks share one bench flow.

Parameters:
C_M_TARGET_SLAVE_BASE_ADDR, 32'h4000_0000, byte address of the first burst
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported
C_M_AXI_BURST_LEN, 16, beats per burst, 1..256
C_NUM_BURSTS, 4, bursts per transaction, >=1

Ports:
ACLK  in  1  sole clock
ARESETN  in  1  asynchronous active-low reset
INIT_AXI_TXN  in  1  start request, rising-edge detected
TXN_DONE  out  1  transaction complete, level
ERROR  out  1  sticky error flag
M_AXI_ARADDR  out  ADDR_WIDTH  burst start address
M_AXI_ARLEN  out  8  C_M_AXI_BURST_LEN-1
M_AXI_ARSIZE  out  3  constant 3'b010
M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
M_AXI_ARVALID  out  1  address valid
M_AXI_ARREADY  in  1  address accepted
M_AXI_RDATA  in  DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  last beat of burst
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
M_AXIS_TDATA  out  DATA_WIDTH  stream data
M_AXIS_TVALID  out  1  stream valid
M_AXIS_TLAST  out  1  final beat of the transaction
M_AXIS_TREADY  in  1  downstream ready

Behaviour:
- Reset (ARESETN low, async): state IDLE; ARVALID, TXN_DONE and ERROR are 0; beat and burst counters are 0; the INIT edge-detect register is 0.
- The start pulse is INIT_AXI_TXN high while its registered copy is low. The block acts on it only in IDLE or DONE. In any other state the pulse is ignored.
- The FSM has four states: IDLE, ADDR, DATA, DONE.
- IDLE/DONE -> ADDR on a start pulse. The transition clears TXN_DONE, ERROR and burst_idx, and loads ARADDR = BASE.
- ADDR: ARVALID=1. ARADDR, ARLEN, ARSIZE and ARBURST are held stable until ARVALID && ARREADY. After that handshake the next cycle drops ARVALID and enters DATA with beat_cnt=0.
- DATA:
  - RREADY = M_AXIS_TREADY, combinational pass-through.
  - M_AXIS_TVALID = M_AXI_RVALID and M_AXIS_TDATA = M_AXI_RDATA, both combinational.
  - Both outputs are gated to 0 outside DATA.
  - A beat transfers when RVALID && RREADY; beat_cnt increments on each transfer.
  - M_AXIS_TLAST = (beat_cnt == BURST_LEN-1) && (burst_idx == NUM_BURSTS-1), gated by DATA.
- End of burst is the beat with beat_cnt == BURST_LEN-1.
  - If burst_idx < NUM_BURSTS-1: burst_idx++, ARADDR += BURST_LEN*4, go to ADDR.
  - Otherwise go to DONE.
- Only one burst is outstanding at a time. ARVALID is never asserted while in DATA.
- DONE: TXN_DONE=1, held until the next start pulse.
- ERROR is set, and stays set until the next start pulse, when a transferred beat has any of:
  - RRESP[1]=1 (SLVERR or DECERR);
  - RLAST=1 with beat_cnt != BURST_LEN-1 (early last);
  - RLAST=0 with beat_cnt == BURST_LEN-1 (missing last). The block still treats this beat as the burst end.
- An error does not abort the sequence: every burst is still issued and TXN_DONE is still reached.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is allowed without any flag. The block does not check 4 KB boundaries; that is the integrator's responsibility.
- Backpressure: TREADY low stalls R with no beat loss or duplication. Latency from R to the stream is 0 cycles.
- ARESETN asserted mid-burst returns the block to IDLE immediately. Outstanding R beats are the slave's concern; after reset the block is ready for a fresh INIT.

Test Plan:
1. Default parameters; slave VIP returns 4x16 beats of data = address; TREADY=1 -> ARADDR sequence 0x4000_0000, 0x40, 0x80, 0xC0 offsets; 64 stream beats in order; TLAST only on beat 64; TXN_DONE=1; ERROR=0.
2. Same as 1 with TREADY toggling 1-of-3 cycles and RVALID randomly stalled -> identical 64-word stream; RREADY tracks TREADY exactly; no dropped or duplicated beats.
3. Slave returns RRESP=2'b10 on beat 5 of burst 2 -> ERROR=1 and stays 1; all 4 bursts still issued; TXN_DONE=1; next INIT clears both.
4. Slave asserts RLAST on beat 10 of burst 0 -> ERROR=1. Separately, RLAST withheld on beat 16 -> ERROR=1 and the next AR issues at offset 0x40.
5. INIT pulsed again during burst 1 -> ignored: exactly 4 ARs are issued; a second INIT after TXN_DONE reruns the full sequence from the base address.
6. ARESETN pulled low during burst 2 for 3 cycles -> all outputs 0 asynchronously, state IDLE; a subsequent INIT completes cleanly with ERROR=0.
